// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot host.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DTR      = 3'd1,
    ST_BOOTWAIT = 3'd2,
    ST_HDR      = 3'd3,
    ST_DATA     = 3'd4,
    ST_ACKWAIT  = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } boot_state_t;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned FRAME_BITS = 10;

  // Little-endian byte idx of the 32-bit length header.
  function automatic logic [7:0] hdr_byte(input logic [31:0] len32, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = len32[7:0];
      2'd1:    b = len32[15:8];
      2'd2:    b = len32[23:16];
      2'd3:    b = len32[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter. A new byte is taken in the last cycle of the
// previous stop bit, so consecutive frames run back-to-back.
module uart_tx_byte
  import uart_boot_pkg::*;
#(
  parameter int unsigned CLK_DIV = 217
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic             active_q, active_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [8:0]       sh_q, sh_d;
  logic             tx_q, tx_d;
  logic             stop_end_s;

  assign stop_end_s = active_q && (bit_q == BIT_LAST) && (div_q == DIV_LAST);
  assign o_ready    = !active_q || stop_end_s;
  assign o_tx       = tx_q;

  // Bit timing, shift register and line level for the current frame.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    if (o_ready && i_valid) begin
      // Start bit goes out now; remaining bits are data LSB first, then stop.
      active_d = 1'b1;
      div_d    = '0;
      bit_d    = 4'd0;
      sh_d     = {1'b1, i_data};
      tx_d     = 1'b0;
    end else if (stop_end_s) begin
      active_d = 1'b0;
      div_d    = '0;
      bit_d    = 4'd0;
      tx_d     = 1'b1;
    end else if (active_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        bit_d = bit_q + 4'd1;
        tx_d  = sh_q[0];
        sh_d  = {1'b1, sh_q[8:1]};
      end else begin
        div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  // Transmitter state registers; line idles high in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= 4'd0;
      sh_q     <= 9'h1FF;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/uart_boot_host.sv
// Host side of the UART bootloader link: pulses DTR, waits for the target
// bootloader, streams a 4-byte length header plus the ROM image, then waits
// for a single acknowledge byte.
module uart_boot_host
  import uart_boot_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 217,
  parameter int unsigned DTR_CYCLES  = 5_500_000,
  parameter int unsigned BOOT_WAIT   = 250_000,
  parameter int          ADDR_W      = 13,
  parameter int unsigned ACK_TIMEOUT = 25_000_000,
  parameter logic [7:0]  ACK_BYTE    = 8'h06
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_len,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_tx,
  output logic              o_dtr_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [ADDR_W:0] ADDR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  boot_state_t     state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [2:0]      hdr_idx_q, hdr_idx_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            dtr_n_q, dtr_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            tx_valid_s;
  logic [7:0]      tx_data_s;
  logic            tx_ready_s;

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (tx_data_s),
    .i_valid (tx_valid_s),
    .o_ready (tx_ready_s),
    .o_tx    (o_tx)
  );

  assign o_mem_addr = addr_q[ADDR_W-1:0];
  assign o_dtr_n    = dtr_n_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

  // Sequencer: next state, shared counter, byte indices and status flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_idx_d  = hdr_idx_q;
    addr_d     = addr_q;
    len_d      = len_q;
    dtr_n_d    = dtr_n_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    tx_valid_s = 1'b0;
    tx_data_s  = 8'h00;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d   = ST_DTR;
          cnt_d     = 32'd0;
          hdr_idx_d = 3'd0;
          addr_d    = '0;
          len_d     = i_len;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_DTR: begin
        // DTR drops one cycle after entry and stays low for DTR_CYCLES.
        if (cnt_q == DTR_CYCLES) begin
          dtr_n_d = 1'b1;
          cnt_d   = 32'd0;
          state_d = ST_BOOTWAIT;
        end else begin
          dtr_n_d = 1'b0;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      ST_BOOTWAIT: begin
        // Leave one cycle early: the transmitter loads the first byte a cycle
        // after HDR is entered, putting the start bit at exactly BOOT_WAIT.
        if (cnt_q + 32'd2 >= BOOT_WAIT) begin
          state_d = ST_HDR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_HDR: begin
        if (hdr_idx_q < 3'(HDR_BYTES)) begin
          tx_valid_s = 1'b1;
          tx_data_s  = hdr_byte(32'(len_q), hdr_idx_q[1:0]);
          if (tx_ready_s) begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end else begin
            hdr_idx_d = hdr_idx_q;
          end
        end else if (len_q != '0) begin
          state_d = ST_DATA;
        end else if (tx_ready_s) begin
          state_d = ST_ACKWAIT;
          cnt_d   = 32'd0;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        // Address already points at the byte to send; it advances on accept
        // so the ROM has a full frame to return the next byte.
        if (addr_q != len_q) begin
          tx_valid_s = 1'b1;
          tx_data_s  = i_mem_data;
          if (tx_ready_s) begin
            addr_d = addr_q + ADDR_ONE;
          end else begin
            addr_d = addr_q;
          end
        end else if (tx_ready_s) begin
          // Last stop bit ends at this edge; the ack timeout starts here.
          state_d = ST_ACKWAIT;
          cnt_d   = 32'd0;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_ACKWAIT: begin
        if (i_rx_valid) begin
          busy_d = 1'b0;
          if (i_rx_data == ACK_BYTE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end else if (cnt_q == ACK_TIMEOUT) begin
          busy_d  = 1'b0;
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        dtr_n_d = 1'b1;
      end
    endcase
  end

  // Sequencer registers; reset releases DTR and clears all status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      hdr_idx_q <= 3'd0;
      addr_q    <= '0;
      len_q     <= '0;
      dtr_n_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_idx_q <= hdr_idx_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      dtr_n_q   <= dtr_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_uart_boot_host.sv
// Self-checking bench for uart_boot_host: table of transfers plus a
// mid-frame reset sequence; a UART monitor checks bytes against a queue.
module tb_uart_boot_host;

  localparam int         CLK_DIV     = 4;
  localparam int         DTR_CYC     = 20;
  localparam int         BOOT_WAIT   = 10;
  localparam int         ADDR_W      = 3;
  localparam int         ACK_TIMEOUT = 120;
  localparam int         ACK_DELAY   = 100;
  localparam logic [7:0] ACK_BYTE    = 8'h06;

  typedef struct {
    int         len;
    logic       send_ack;
    logic [7:0] ack;
    logic       disturb;
    logic       exp_done;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              tx;
  logic              dtr_n;
  logic              busy;
  logic              done;
  logic              error;

  logic [7:0] rom [0:7];
  logic [7:0] exp_q [$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         rst_gen = 0;
  int         last_start_cyc = 0;

  uart_boot_host #(
    .CLK_DIV(CLK_DIV), .DTR_CYCLES(DTR_CYC), .BOOT_WAIT(BOOT_WAIT),
    .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT), .ACK_BYTE(ACK_BYTE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
    .o_mem_addr(mem_addr), .i_mem_data(mem_data), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .o_tx(tx), .o_dtr_n(dtr_n), .o_busy(busy),
    .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) mem_data <= rom[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART monitor: decodes 8N1 frames and compares against the queue.
  initial begin : uart_mon
    logic [7:0] b;
    logic       start_ok;
    logic       stop_ok;
    int         gen;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        gen = rst_gen;
        last_start_cyc = cyc;
        repeat (CLK_DIV / 2) @(negedge clk);
        start_ok = (tx === 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[k] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        stop_ok = (tx === 1'b1);
        repeat (CLK_DIV - CLK_DIV / 2 - 1) @(negedge clk);
        if (gen == rst_gen) begin
          check("start_bit", 32'(start_ok), 32'd1);
          check("stop_bit", 32'(stop_ok), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h, expected no byte", b);
          end else begin
            check("tx_byte", 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push_expected(input int l);
    logic [31:0] l32;
    l32 = 32'(l);
    exp_q.push_back(l32[7:0]);
    exp_q.push_back(l32[15:8]);
    exp_q.push_back(l32[23:16]);
    exp_q.push_back(l32[31:24]);
    for (int i = 0; i < l; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic pulse_start(input int l);
    @(negedge clk);
    len   = (ADDR_W + 1)'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    int rel;
    int e;
    int guard;
    int lowcnt;
    push_expected(v.len);
    pulse_start(v.len);
    t0 = cyc;
    check("start_busy", 32'(busy), 32'd1);
    check("start_clears_done", 32'(done), 32'd0);
    check("start_clears_error", 32'(error), 32'd0);
    guard = 0;
    while (dtr_n !== 1'b0 && guard < 10) begin @(negedge clk); guard++; end
    check("dtr_fall_delay", 32'(cyc - t0), 32'd1);
    lowcnt = 0;
    while (dtr_n === 1'b0 && lowcnt < 1000) begin lowcnt++; @(negedge clk); end
    check("dtr_low_cycles", 32'(lowcnt), 32'(DTR_CYC));
    rel = cyc;
    guard = 0;
    while (tx !== 1'b0 && guard < 1000) begin @(negedge clk); guard++; end
    check("boot_wait_cycles", 32'(cyc - rel), 32'(BOOT_WAIT));
    if (v.disturb) begin
      // Inside the first data frame: stray start and ack must be ignored.
      repeat (180) @(negedge clk);
      start    = 1'b1;
      len      = (ADDR_W + 1)'(1);
      rx_data  = ACK_BYTE;
      rx_valid = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      check("busy_after_stray_start", 32'(busy), 32'd1);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20000) begin @(negedge clk); guard++; end
    check("all_bytes_sent", 32'(exp_q.size()), 32'd0);
    e = last_start_cyc + 10 * CLK_DIV;
    guard = 0;
    while (cyc < e && guard < 100) begin @(negedge clk); guard++; end
    check("busy_in_ackwait", 32'(busy), 32'd1);
    if (v.send_ack) begin
      repeat (ACK_DELAY) @(negedge clk);
      rx_data  = v.ack;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end else begin
      guard = 0;
      while (error !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
      check("ack_timeout_cycles", 32'(cyc - e), 32'(ACK_TIMEOUT + 1));
    end
    check("done_flag", 32'(done), 32'(v.exp_done));
    check("error_flag", 32'(error), 32'(!v.exp_done));
    check("busy_end", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("flags_sticky", 32'({done, error}), 32'({v.exp_done, !v.exp_done}));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs [6];
    int   zeros;
    int   guard;

    rom[0] = 8'hA5; rom[1] = 8'h00; rom[2] = 8'hFF; rom[3] = 8'h3C;
    rom[4] = 8'h81; rom[5] = 8'h7E; rom[6] = 8'h12; rom[7] = 8'hC9;

    vecs[0] = '{len: 3, send_ack: 1'b1, ack: 8'h06, disturb: 1'b0, exp_done: 1'b1};
    vecs[1] = '{len: 1, send_ack: 1'b1, ack: 8'h06, disturb: 1'b0, exp_done: 1'b1};
    vecs[2] = '{len: 0, send_ack: 1'b1, ack: 8'h06, disturb: 1'b0, exp_done: 1'b1};
    vecs[3] = '{len: 8, send_ack: 1'b1, ack: 8'h06, disturb: 1'b1, exp_done: 1'b1};
    vecs[4] = '{len: 2, send_ack: 1'b1, ack: 8'h15, disturb: 1'b0, exp_done: 1'b0};
    vecs[5] = '{len: 1, send_ack: 1'b0, ack: 8'h00, disturb: 1'b0, exp_done: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_dtr_n", 32'(dtr_n), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of the sixth frame (image byte 1 of an 8-byte image).
    push_expected(8);
    pulse_start(8);
    guard = 0;
    while (exp_q.size() > 7 && guard < 5000) begin @(negedge clk); guard++; end
    check("reached_byte5", 32'(exp_q.size()), 32'd7);
    repeat (6) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    rst_gen++;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_dtr_n", 32'(dtr_n), 32'd1);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    check("async_reset_error", 32'(error), 32'd0);
    check("async_reset_mem_addr", 32'(mem_addr), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    zeros = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("no_tx_after_reset", 32'(zeros), 32'd0);
    check("idle_dtr_after_reset", 32'(dtr_n), 32'd1);
    check("idle_busy_after_reset", 32'(busy), 32'd0);

    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
